bypass_network_param: RTL
=========================

# bypass_network_param

Parametrised operand bypass network for the backend execution pipes. Each producer lane feeds a DEPTH-entry result delay line with per-entry valid tracking. Each consumer operand port selects one (lane, stage) entry, or falls back to its register-file read data when no valid entry is selected. Sits between the register-read stage and the execution units; replaces fixed two-stage per-pipe bypassing with configurable lane count, depth, consumer count and an optional output register, and adds miss detection and a miss counter.

## Interface
- DATA_WIDTH, 64, width of one operand value
- NUM_PROD, 4, number of producer lanes (int, mem, complex, fp lanes flattened)
- DEPTH, 2, delay-line stages per producer lane (stage 0 = youngest), ≥1
- NUM_CONS, 6, number of consumer operand ports
- OUT_REG, 0, 1 = register consumer outputs (adds one cycle)
- PW = max(1, $clog2(NUM_PROD)) and SW = max(1, $clog2(DEPTH)), derived localparams
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold all delay-line stages and output registers
- flush  in  1  synchronous clear of all stages and output registers
- prod_valid  in  NUM_PROD  producer result valid this cycle
- prod_data  in  NUM_PROD*DATA_WIDTH  producer result, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- sel_en  in  NUM_CONS  consumer requests bypass
- sel_prod  in  NUM_CONS*PW  selected lane per consumer
- sel_stage  in  NUM_CONS*SW  selected stage per consumer
- rf_data  in  NUM_CONS*DATA_WIDTH  register-file fallback per consumer
- out_data  out  NUM_CONS*DATA_WIDTH  operand value per consumer
- out_hit  out  NUM_CONS  1 = out_data came from a valid bypass entry
- miss  out  NUM_CONS  sel_en set but entry invalid or index out of range
- miss_count  out  16  saturating count of non-stalled cycles with any miss

## Operation
- Delay line: entry[p][0] <= {prod_valid[p], prod_data[p]}; entry[p][k] <= entry[p][k-1] for k ≥ 1.
- Update priority per edge: rst > flush > stall > shift. rst and flush set every entry's valid and data to 0. stall holds every entry.
- Select per consumer c, using the combinational path:
  - in range when sel_prod < NUM_PROD and sel_stage < DEPTH.
  - hit = sel_en & in_range & entry[sel_prod][sel_stage].valid.
  - out_data = hit ? entry data : rf_data[c].
  - miss = sel_en & ~hit.
  - sel_en = 0 gives out_data = rf_data, hit = 0, miss = 0.
- Out-of-range index never indexes the array. Result is miss = 1 and rf_data passed through.
- OUT_REG=1: out_data, out_hit and miss are registered from the combinational path.
  - Same priority: rst/flush clear to 0; stall holds.
- miss_count: on each edge with ~stall and |miss_comb, increment. Saturates at 16'hFFFF. rst clears it to 0. flush does not clear it.
  - miss_comb is the combinational miss vector, before any output register.

## Timing
- Reset values: all entries 0/invalid; miss_count 0.
  - OUT_REG=0: out_data = rf_data, out_hit = 0, miss = sel_en.
  - OUT_REG=1: all outputs 0.
- Producer result presented in cycle t:
  - visible at stage 0 in cycle t+1.
  - visible at stage k in cycle t+1+k, with no stalls.
- Each stalled cycle delays visibility by one cycle.
- Consumer latency: 0 cycles with OUT_REG=0, 1 cycle with OUT_REG=1.
- flush together with stall: flush wins; all entries are invalid next cycle.
- Result at stage DEPTH-1 is dropped on the next non-stalled edge.
- Several consumers may select the same entry in one cycle. All receive identical data.
- rst asserted mid-stream clears everything on that edge, regardless of stall or flush.

## Test plan
- Shift/select, DEPTH=2, NUM_PROD=4:
  - stimulus: lane 2 valid with 0xA5A5 at t0; consumer 0 selects (2,0) at t1 and (2,1) at t2.
  - response: out_data = 0xA5A5 and out_hit = 1 at both; at t3 selecting (2,1) gives rf_data and miss = 1.
- Stall hold: assert stall at t1 for 3 cycles.
  - response: (2,0) keeps returning 0xA5A5 throughout the stall; the value appears at (2,1) one cycle after stall drops.
- Flush priority: flush and stall together with both stages valid.
  - response: next cycle every selection misses, out_data = rf_data, and miss_count increments by exactly 1 per non-stalled missing cycle.
- Out of range, NUM_PROD=3: sel_prod = 3 with sel_en = 1 and rf_data = 0x1234.
  - response: out_data = 0x1234, miss = 1, out_hit = 0.
  - With sel_en = 0: miss = 0.
- Counter saturation: force 65540 non-stalled miss cycles.
  - response: miss_count = 0xFFFF; rst returns it to 0.
- OUT_REG=1 with 6 consumers all selecting lane 0 stage 0, one cycle after 0xDEAD entered.
  - response: all six out_data = 0xDEAD one cycle later; rst zeroes all outputs.

Source files
------------

// File: rtl/bypass_network_param.sv
// Parametrised operand bypass network: per-lane result delay lines
// with per-consumer (lane, stage) selection and register-file fallback.
module bypass_network_param #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PROD   = 4,
    parameter int DEPTH      = 2,
    parameter int NUM_CONS   = 6,
    parameter int OUT_REG    = 0,
    localparam int PW = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1,
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           flush,
    input  logic [NUM_PROD-1:0]            prod_valid,
    input  logic [NUM_PROD*DATA_WIDTH-1:0] prod_data,
    input  logic [NUM_CONS-1:0]            sel_en,
    input  logic [NUM_CONS*PW-1:0]         sel_prod,
    input  logic [NUM_CONS*SW-1:0]         sel_stage,
    input  logic [NUM_CONS*DATA_WIDTH-1:0] rf_data,
    output logic [NUM_CONS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_CONS-1:0]            out_hit,
    output logic [NUM_CONS-1:0]            miss,
    output logic [15:0]                    miss_count
);

    logic [NUM_PROD-1:0][DEPTH-1:0]                 ent_valid;
    logic [NUM_PROD-1:0][DEPTH-1:0][DATA_WIDTH-1:0] ent_data;

    logic [NUM_CONS-1:0][DATA_WIDTH-1:0] pick_data;
    logic [NUM_CONS*DATA_WIDTH-1:0]      data_comb;
    logic [NUM_CONS-1:0]                 hit_comb;
    logic [NUM_CONS-1:0]                 miss_comb;

    // Delay line: stage 0 captures producers, older stages shift down.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ent_valid <= '0;
            ent_data  <= '0;
        end else if (!stall) begin
            for (int p = 0; p < NUM_PROD; p++) begin
                ent_valid[p][0] <= prod_valid[p];
                ent_data[p][0]  <= prod_data[p*DATA_WIDTH +: DATA_WIDTH];
                for (int k = 1; k < DEPTH; k++) begin
                    ent_valid[p][k] <= ent_valid[p][k-1];
                    ent_data[p][k]  <= ent_data[p][k-1];
                end
            end
        end
    end

    // Match each consumer index against every real entry; an
    // out-of-range index simply matches nothing and falls back.
    always_comb begin
        pick_data = '0;
        hit_comb  = '0;
        miss_comb = '0;
        data_comb = rf_data;
        for (int c = 0; c < NUM_CONS; c++) begin
            for (int p = 0; p < NUM_PROD; p++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (sel_prod[c*PW +: PW] == PW'(p) &&
                        sel_stage[c*SW +: SW] == SW'(k)) begin
                        hit_comb[c]  = sel_en[c] & ent_valid[p][k];
                        pick_data[c] = ent_data[p][k];
                    end
                end
            end
            miss_comb[c] = sel_en[c] & ~hit_comb[c];
            if (hit_comb[c]) begin
                data_comb[c*DATA_WIDTH +: DATA_WIDTH] = pick_data[c];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [NUM_CONS*DATA_WIDTH-1:0] data_q;
            logic [NUM_CONS-1:0]            hit_q;
            logic [NUM_CONS-1:0]            miss_q;

            // Optional output stage with the same clear/hold rules.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    data_q <= '0;
                    hit_q  <= '0;
                    miss_q <= '0;
                end else if (!stall) begin
                    data_q <= data_comb;
                    hit_q  <= hit_comb;
                    miss_q <= miss_comb;
                end
            end

            assign out_data = data_q;
            assign out_hit  = hit_q;
            assign miss     = miss_q;
        end else begin : g_comb
            assign out_data = data_comb;
            assign out_hit  = hit_comb;
            assign miss     = miss_comb;
        end
    endgenerate

    // Saturating count of advancing cycles with at least one miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_count <= '0;
        end else if (!stall && (|miss_comb) && miss_count != 16'hFFFF) begin
            miss_count <= miss_count + 16'd1;
        end
    end

endmodule
